// File: rtl/muldiv_sequencer_if.sv
// Bus between the EX stage and the iterative multiply/divide sequencer.
// Handshake: the EX stage holds start (with op/opA/opB) high for as long as
// the instruction sits in EX; while stall=1 the pipeline is frozen, so start
// stays asserted. done is a one-cycle result-valid pulse, and result is
// meaningful while done=1. flush kills the EX instruction in any state.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    // EX-stage side
    modport master (
        output start, op, opA, opB, flush,
        input  stall, done, result
    );

    // Sequencer side
    modport slave (
        input  start, op, opA, opB, flush,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit beside the EX-stage ALU.
// MUL/MULHU use a shift-add product held in {hi_q, lo_q}; DIVU/REMU use a
// restoring divider with the remainder in hi_q and the quotient in lo_q.
// One iteration per cycle, WIDTH iterations per operation. Divide by zero
// skips the iterations and goes straight to DONE.
// dbg_state_o encoding: 0 IDLE, 1 RUN, 2 DONE.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus,
    output logic [1:0]        dbg_state_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand or divisor
    logic [WIDTH:0]   hi_q, hi_d;         // product upper half / remainder
    logic [WIDTH-1:0] lo_q, lo_d;         // multiplier / quotient
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             stall_c;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH:0]   iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_sel;

    // One multiply or divide iteration computed from the current registers
    always_comb begin
        mul_sum   = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        iter_hi   = hi_q;
        iter_lo   = lo_q;
        if (op_q[1]) begin
            // Trial subtraction; a clear top bit means no borrow
            if (!div_diff[WIDTH+1]) begin
                iter_hi = div_diff[WIDTH:0];
                iter_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                iter_hi = div_shift;
                iter_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add-then-shift keeps the carry out of the upper half
            iter_hi = {1'b0, mul_sum[WIDTH:1]};
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        // op bit 0 selects the upper half (MULHU) or the remainder (REMU)
        iter_sel = op_q[0] ? iter_hi[WIDTH-1:0] : iter_lo;
    end

    // Next-state, datapath update and stall generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        result_d = result_q;
        stall_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    stall_c = 1'b1;
                    op_d    = bus.op;
                    mcand_d = bus.opB;
                    hi_d    = '0;
                    lo_d    = bus.opA;
                    cnt_d   = '0;
                    if (bus.op[1] && (bus.opB == '0)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = bus.op[0] ? bus.opA : '1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    hi_d    = iter_hi;
                    lo_d    = iter_lo;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d    = '0;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = iter_sel;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.stall   = stall_c;
    assign bus.done    = done_q & ~bus.flush;
    assign bus.result  = result_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases, flush, async reset,
// back-to-back ops and randomized ops against an arithmetic reference.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;

    // Clock and reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();
    logic [1:0] dbg_state;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_exp = '0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain unsigned arithmetic
    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        case (op)
            2'd0:    return p[WIDTH-1:0];
            2'd1:    return p[2*WIDTH-1:WIDTH];
            2'd2:    return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 result=0x%0h, required no pulse at %0t",
                         bus.result, $time);
            end else begin
                check("result", bus.result, exp_q.pop_front());
            end
        end
    end

    // Issue one op, hold start until the DONE cycle ends; returns at posedge+1
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        int  stalls = 0;
        int  waited = 0;
        int  exp_lat;
        bit  got = 0;
        logic [WIDTH-1:0] expv;
        expv    = ref_result(op, a, b);
        exp_lat = (op[1] && b == '0) ? 1 : WIDTH + 1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        exp_q.push_back(expv);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) check("idle_before_accept", {30'd0, dbg_state}, 32'd0);
            if (bus.done) begin
                got = 1;
                check("stall_in_done", {31'd0, bus.stall}, 32'd0);
                break;
            end
            if (bus.stall) stalls++;
            waited++;
            // Inputs after acceptance must not matter
            if (c > 0) begin
                bus.op  = 2'($urandom);
                bus.opA = $urandom;
                bus.opB = $urandom;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done in 200 cycles, required one (op=%0d)", op);
            void'(exp_q.pop_back());
        end else begin
            last_exp = expv;
        end
        check("latency", WIDTH'(waited), WIDTH'(exp_lat));
        check("stall_cycles", WIDTH'(stalls), WIDTH'(exp_lat));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Idle cycles: no done, result held; starts and ends at posedge+1
    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_no_done", {31'd0, bus.done}, 32'd0);
            check("result_hold", bus.result, last_exp);
            @(posedge clk);
            #1;
        end
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        logic [1:0]       rop;
        logic [WIDTH-1:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.opA   = '0;
        bus.opB   = '0;
        bus.flush = 1'b0;

        // Reset state; stall follows its equation even in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        bus.start = 1'b1;
        #1;
        check("reset_stall_eq", {31'd0, bus.stall}, 32'd1);
        bus.start = 1'b0;
        #1;
        check("reset_stall_idle", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        run_op(2'd0, 32'd7, 32'd6);                idle(2);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(1);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(1);
        run_op(2'd2, 32'd100, 32'd7);              idle(1);
        run_op(2'd3, 32'd100, 32'd7);              idle(1);
        run_op(2'd2, 32'd5, 32'd9);                idle(1);
        run_op(2'd3, 32'd5, 32'd9);                idle(1);
        run_op(2'd2, 32'd123, 32'd0);              idle(1);
        run_op(2'd3, 32'd123, 32'd0);              idle(2);

        // Flush 10 cycles into RUN: no done, back to IDLE
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.opA   = 32'd1234;
        bus.opB   = 32'd99;
        @(posedge clk);          // accept edge
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'd0, bus.stall}, 32'd0);
        check("flush_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush_to_idle", {30'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1;
        idle(40);
        run_op(2'd2, 32'd1000, 32'd33);            idle(1);

        // Async reset 20 cycles into RUN, between edges
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.opA   = 32'hDEAD_BEEF;
        bus.opB   = 32'h1234_5678;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        check("rst_run_state", {30'd0, dbg_state}, 32'd0);
        check("rst_run_done", {31'd0, bus.done}, 32'd0);
        check("rst_run_result", bus.result, 32'd0);
        last_exp = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back pair: one IDLE cycle between them
        run_op(2'd0, 32'd3, 32'd5);
        run_op(2'd2, 32'd15, 32'd4);
        idle(2);

        // Randomized ops with random gaps
        for (int k = 0; k < 30; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = WIDTH'($urandom_range(0, 3));
                1:       rb = WIDTH'($urandom_range(0, 1000));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
            idle($urandom_range(0, 3));
        end

        idle(3);
        check("queue_empty", WIDTH'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
